// File: rtl/vram_arb_pkg.sv
// vram_arb_pkg: shared definitions for the VRAM arbiter.
//   arb_state_t      FSM state encoding
//   WAIT_STATES_MAX  largest number of CPU wait states supported by the
//                    3-bit wait counter
//   strobes_t        grouped active-low SRAM strobes
//   STROBES_IDLE     all strobes deasserted (bus released)
package vram_arb_pkg;

  typedef enum logic [2:0] {
    ST_CPU      = 3'd0,
    ST_CPU_WAIT = 3'd1,
    ST_SWITCH   = 3'd2,
    ST_DMA      = 3'd3,
    ST_RELEASE  = 3'd4
  } arb_state_t;

  localparam int unsigned WAIT_STATES_MAX = 7;

  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
  } strobes_t;

  localparam strobes_t STROBES_IDLE = 3'b111;

endpackage

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one asynchronous SRAM between a CPU and a VPU DMA
// read port. The CPU owns the bus by default. The VPU requests it with
// dma_hold, is granted with hlda, and reads with the dma_cs strobe.
//
// Ports:
//   clk, rst                    clock and asynchronous active-high reset
//   cpu_addr/do/rw/vma          CPU access request (rw=1 means read)
//   cpu_di, cpu_halt            CPU read data and stall
//   dma_hold/addr/cs            VPU bus request, address, read strobe
//   dma_data                    VPU read data
//   hlda, dma_err               bus grant, sticky strobe-without-grant flag
//   mem_*                       SRAM port, strobes active-low
//
// Build option: define VRAM_ARB_WAIT_EN to enable CPU wait states
// (WAIT_STATES, clamped to 7). Without it every CPU access takes one cycle
// and WAIT_STATES has no effect.
//
// state     | meaning
// CPU       | CPU owns the bus, strobes follow the CPU directly
// CPU_WAIT  | CPU access stretched, address/strobes held from access start
// SWITCH    | bus idle for one cycle before handing over to DMA
// DMA       | VPU owns the bus, hlda high
// RELEASE   | bus idle for one cycle before handing back to CPU
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_do,
  input  logic        cpu_rw,
  input  logic        cpu_vma,
  output logic [7:0]  cpu_di,
  output logic        cpu_halt,
  input  logic        dma_hold,
  input  logic [15:0] dma_addr,
  input  logic        dma_cs,
  output logic [7:0]  dma_data,
  output logic        hlda,
  output logic        dma_err,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_dout,
  input  logic [7:0]  mem_din,
  output logic        mem_ce_n,
  output logic        mem_oe_n,
  output logic        mem_we_n
);

  arb_state_t state;
  logic       dma_err_q;
  logic [7:0] rd_capture;
  logic       cpu_read;
  logic       cpu_write;
  logic       access_stall;
  strobes_t   strobes;

`ifdef VRAM_ARB_WAIT_EN
  localparam logic [2:0] WS = (WAIT_STATES > WAIT_STATES_MAX) ?
                              3'(WAIT_STATES_MAX) : 3'(WAIT_STATES);
  localparam bit WAIT_ACTIVE = (WS != 3'd0);

  logic [2:0]  wait_cnt;
  logic [15:0] held_addr;
  logic [7:0]  held_do;
  logic        held_rw;
`else
  // Parameter is accepted for interface compatibility but never stalls.
  localparam bit WAIT_ACTIVE = 1'b0 && (WAIT_STATES != 0);
`endif

  assign cpu_read     = cpu_vma & cpu_rw;
  assign cpu_write    = cpu_vma & ~cpu_rw;
  assign access_stall = cpu_vma & WAIT_ACTIVE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_CPU;
      dma_err_q  <= 1'b0;
      rd_capture <= 8'h00;
`ifdef VRAM_ARB_WAIT_EN
      wait_cnt   <= 3'd0;
      held_addr  <= 16'h0000;
      held_do    <= 8'h00;
      held_rw    <= 1'b1;
`endif
    end else begin
      if (dma_cs && (state != ST_DMA))
        dma_err_q <= 1'b1;

      case (state)
        ST_CPU: begin
`ifdef VRAM_ARB_WAIT_EN
          if (access_stall) begin
            state     <= ST_CPU_WAIT;
            wait_cnt  <= WS - 3'd1;
            held_addr <= cpu_addr;
            held_do   <= cpu_do;
            held_rw   <= cpu_rw;
          end else
`endif
          begin
            if (cpu_read)
              rd_capture <= mem_din;
            // A CPU access in the same cycle keeps the bus; hold is re-examined next cycle.
            if (dma_hold && !cpu_vma)
              state <= ST_SWITCH;
          end
        end
`ifdef VRAM_ARB_WAIT_EN
        ST_CPU_WAIT: begin
          if (wait_cnt == 3'd0) begin
            if (held_rw)
              rd_capture <= mem_din;
            state <= ST_CPU;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
`endif
        ST_SWITCH: state <= ST_DMA;
        ST_DMA:    if (!dma_hold) state <= ST_RELEASE;
        default:   state <= ST_CPU;
      endcase
    end
  end

  always_comb begin
    mem_addr = cpu_addr;
    mem_dout = cpu_do;
    strobes  = STROBES_IDLE;
    cpu_halt = 1'b1;
    hlda     = 1'b0;
    cpu_di   = rd_capture;
    dma_data = 8'hFF;
    case (state)
      ST_CPU: begin
        strobes  = {~cpu_vma, ~cpu_read, ~cpu_write};
        cpu_halt = access_stall;
        cpu_di   = mem_din;
      end
`ifdef VRAM_ARB_WAIT_EN
      ST_CPU_WAIT: begin
        mem_addr = held_addr;
        mem_dout = held_do;
        strobes  = {1'b0, ~held_rw, held_rw};
        cpu_halt = (wait_cnt != 3'd0);
        cpu_di   = mem_din;
      end
`endif
      ST_DMA: begin
        hlda     = 1'b1;
        mem_addr = dma_addr;
        strobes  = {~dma_cs, ~dma_cs, 1'b1};
        dma_data = mem_din;
      end
      default: ;
    endcase
    // Reset releases the bus immediately, aborting any write in flight.
    if (rst) begin
      strobes  = STROBES_IDLE;
      cpu_halt = 1'b0;
      hlda     = 1'b0;
    end
  end

  assign mem_ce_n = strobes.ce_n;
  assign mem_oe_n = strobes.oe_n;
  assign mem_we_n = strobes.we_n;
  assign dma_err  = dma_err_q;

endmodule

// File: tb/tb_vram_arbiter.sv
`timescale 1ns/1ps
module tb_vram_arbiter;

  localparam int WS = 2;
`ifdef VRAM_ARB_WAIT_EN
  localparam int WS_EFF = WS;
`else
  localparam int WS_EFF = 0;
`endif
  localparam int K_RD  = 0;
  localparam int K_WR  = 1;
  localparam int K_DMA = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_do = '0;
  logic        cpu_rw = 1'b1;
  logic        cpu_vma = 1'b0;
  logic [7:0]  cpu_di;
  logic        cpu_halt;
  logic        dma_hold = 1'b0;
  logic [15:0] dma_addr = '0;
  logic        dma_cs = 1'b0;
  logic [7:0]  dma_data;
  logic        hlda;
  logic        dma_err;
  logic [15:0] mem_addr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        mem_ce_n;
  logic        mem_oe_n;
  logic        mem_we_n;

  always #5 clk = ~clk;

  vram_arbiter #(.WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_do(cpu_do), .cpu_rw(cpu_rw), .cpu_vma(cpu_vma),
    .cpu_di(cpu_di), .cpu_halt(cpu_halt),
    .dma_hold(dma_hold), .dma_addr(dma_addr), .dma_cs(dma_cs), .dma_data(dma_data),
    .hlda(hlda), .dma_err(dma_err),
    .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_din(mem_din),
    .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n)
  );

  // SRAM environment model
  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  logic [7:0] sram [0:65535];
  initial for (int i = 0; i < 65536; i++) sram[i] = init_val(16'(i));
  always @(posedge clk) if (!mem_ce_n && !mem_we_n) sram[mem_addr] <= mem_dout;
  assign mem_din = (!mem_ce_n && !mem_oe_n) ? sram[mem_addr] : 8'hEE;

  // Reference model: memory contents as the bus protocol should leave them
  logic [7:0] ref_mem [logic [15:0]];
  function automatic logic [7:0] ref_read(input logic [15:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_val(a);
  endfunction

  typedef struct {
    int          kind;
    logic [15:0] addr;
    logic [7:0]  data;
    bit          granted;
  } exp_t;
  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] rand_addr();
    return ($urandom_range(0, 1) != 0 ? 16'h8000 : 16'h1230) + 16'($urandom_range(0, 15));
  endfunction

  // Monitor: pops expectations whenever the DUT completes a CPU access or
  // presents DMA read data.
  int         halt_cnt = 0;
  int         strobe_cnt = 0;
  bit         err_model = 1'b0;
  logic [7:0] last_rd = 8'h00;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      halt_cnt   = 0;
      strobe_cnt = 0;
      err_model  = 1'b0;
      last_rd    = 8'h00;
    end else begin
      check("dma_err", dma_err, err_model);
      if (hlda) check("cpu_di_held", cpu_di, last_rd);
      if (cpu_vma) begin
        if (cpu_rw ? !mem_oe_n : !mem_we_n) strobe_cnt++;
        if (cpu_halt) halt_cnt++;
        else begin
          if (sb.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL cpu_unexpected: access completed, expected nothing pending");
          end else begin
            e = sb.pop_front();
            check("cpu_kind", 16'(cpu_rw ? K_RD : K_WR), 16'(e.kind));
            check("cpu_halt_cycles", 16'(halt_cnt), 16'(WS_EFF));
            check("cpu_strobe_cycles", 16'(strobe_cnt), 16'(WS_EFF + 1));
            check("cpu_mem_addr", mem_addr, e.addr);
            if (e.kind == K_RD) begin
              check("cpu_di", cpu_di, e.data);
              last_rd = e.data;
            end else begin
              check("cpu_mem_dout", mem_dout, e.data);
            end
          end
          halt_cnt   = 0;
          strobe_cnt = 0;
        end
      end
      if (dma_cs) begin
        if (sb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL dma_unexpected: dma_cs seen, expected nothing pending");
        end else begin
          e = sb.pop_front();
          check("dma_kind", 16'(K_DMA), 16'(e.kind));
          check("dma_grant", hlda, e.granted);
          check("dma_data", dma_data, e.data);
          if (!e.granted) err_model = 1'b1;
        end
      end
    end
  end

  task automatic cpu_access(input logic rw, input logic [15:0] a, input logic [7:0] d,
                            input bit with_hold);
    exp_t e;
    bit   done;
    @(posedge clk); #1;
    cpu_addr = a; cpu_do = d; cpu_rw = rw; cpu_vma = 1'b1;
    if (with_hold) dma_hold = 1'b1;
    e.kind = rw ? K_RD : K_WR;
    e.addr = a;
    e.data = rw ? ref_read(a) : d;
    e.granted = 1'b0;
    sb.push_back(e);
    if (!rw) ref_mem[a] = d;
    done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!cpu_halt) begin done = 1'b1; break; end
    end
    check("cpu_timeout", 16'(done), 16'd1);
    @(posedge clk); #1;
    cpu_vma = 1'b0;
  endtask

  task automatic dma_burst(input int n);
    exp_t e;
    @(posedge clk); #1;
    dma_hold = 1'b1;
    @(posedge clk); #1;
    check("switch_hlda", hlda, 1'b0);
    check("switch_halt", cpu_halt, 1'b1);
    check("switch_ce", mem_ce_n, 1'b1);
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      e.kind = K_DMA; e.addr = rand_addr(); e.data = ref_read(e.addr); e.granted = 1'b1;
      dma_addr = e.addr; dma_cs = 1'b1;
      sb.push_back(e);
      @(posedge clk); #1;
    end
    dma_cs = 1'b0; dma_hold = 1'b0;
    @(posedge clk); #1;
    check("release_hlda", hlda, 1'b0);
    check("release_halt", cpu_halt, 1'b1);
    @(posedge clk); #1;
    check("back_to_cpu_halt", cpu_halt, 1'b0);
  endtask

  task automatic hold_during_access();
    exp_t e;
    cpu_access(1'b1, 16'h1234, 8'h00, 1'b1);
    check("access_first_halt", cpu_halt, 1'b0);
    check("access_first_hlda", hlda, 1'b0);
    e.kind = K_DMA; e.addr = 16'h8001; e.data = 8'hFF; e.granted = 1'b0;
    dma_addr = e.addr; dma_cs = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    dma_cs = 1'b0;
    check("late_switch_hlda", hlda, 1'b0);
    check("late_switch_halt", cpu_halt, 1'b1);
    @(posedge clk); #1;
    e.kind = K_DMA; e.addr = 16'h8002; e.data = ref_read(16'h8002); e.granted = 1'b1;
    dma_addr = e.addr; dma_cs = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    dma_cs = 1'b0; dma_hold = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic write_abort();
    @(posedge clk); #1;
    cpu_addr = 16'h1234; cpu_do = 8'hA5; cpu_rw = 1'b0; cpu_vma = 1'b1;
    #1;
    check("abort_pre_we", mem_we_n, 1'b0);
    rst = 1'b1;
    #1;
    check("abort_we", mem_we_n, 1'b1);
    check("abort_ce", mem_ce_n, 1'b1);
    cpu_vma = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic reset_in_dma();
    @(posedge clk); #1;
    dma_hold = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    check("pre_rst_hlda", hlda, 1'b1);
    dma_addr = 16'h8003; dma_cs = 1'b1;
    #1;
    check("pre_rst_ce", mem_ce_n, 1'b0);
    rst = 1'b1;
    #1;
    check("rst_dma_ce", mem_ce_n, 1'b1);
    check("rst_dma_oe", mem_oe_n, 1'b1);
    check("rst_dma_hlda", hlda, 1'b0);
    check("rst_dma_halt", cpu_halt, 1'b0);
    dma_cs = 1'b0; dma_hold = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_hlda", hlda, 1'b0);
    check("post_rst_halt", cpu_halt, 1'b0);
  endtask

  initial begin
    cpu_vma = 1'b1; cpu_rw = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_halt", cpu_halt, 1'b0);
    check("rst_hlda", hlda, 1'b0);
    check("rst_err", dma_err, 1'b0);
    check("rst_we", mem_we_n, 1'b1);
    check("rst_ce", mem_ce_n, 1'b1);
    cpu_vma = 1'b0; cpu_rw = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    cpu_access(1'b0, 16'h1234, 8'h5A, 1'b0);
    cpu_access(1'b1, 16'h1234, 8'h00, 1'b0);
    cpu_access(1'b1, 16'h1235, 8'h00, 1'b0);
    dma_burst(2);
    hold_during_access();
    write_abort();
    cpu_access(1'b1, 16'h1234, 8'h00, 1'b0);
    reset_in_dma();

    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 2))
        0: cpu_access(1'b1, rand_addr(), 8'h00, 1'b0);
        1: cpu_access(1'b0, rand_addr(), 8'($urandom_range(0, 255)), 1'b0);
        default: dma_burst(int'($urandom_range(1, 4)));
      endcase
    end

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", 16'(sb.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter WAIT_STATES, default 1: extra clk cycles per CPU memory access, range 0..7.
REQ-002 clk  in  1  system clock, all logic on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 cpu_addr in 16, cpu_do in 8 (write data), cpu_rw in 1 (1=read), cpu_vma in 1 (valid memory access).
REQ-005 cpu_di out 8: read data to CPU. cpu_halt out 1: stalls the CPU while high.
REQ-006 dma_hold in 1: VPU bus request. dma_addr in 16. dma_cs in 1: VPU read strobe. dma_data out 8: read data to VPU.
REQ-007 hlda out 1: bus granted to DMA. dma_err out 1: sticky protocol-error flag.
REQ-008 mem_addr out 16, mem_dout out 8, mem_din in 8, mem_ce_n / mem_oe_n / mem_we_n out 1 each: async SRAM port, strobes active-low.

Function
REQ-009 FSM states: CPU, CPU_WAIT, SWITCH, DMA, RELEASE; the state is registered.
REQ-010 CPU: mem_addr=cpu_addr, mem_dout=cpu_do, mem_ce_n=~cpu_vma, mem_oe_n=~(cpu_vma&cpu_rw), mem_we_n=~(cpu_vma&~cpu_rw); cpu_di=mem_din combinationally.
REQ-011 CPU with cpu_vma=1 and WAIT_STATES>0: cpu_halt=1 combinationally, next state CPU_WAIT, wait counter loaded with WAIT_STATES-1.
REQ-012 CPU_WAIT: strobes and address held from the access start; cpu_halt=1 until the counter reaches 0, then cpu_halt=0 for that cycle; next state CPU.
REQ-013 CPU with dma_hold=1 and no access starting: next state SWITCH. An access starting in the same cycle wins and is serviced first.
REQ-014 SWITCH: all strobes high, cpu_halt=1, hlda=0; next state DMA unconditionally; lasts exactly 1 cycle.
REQ-015 DMA: hlda=1, cpu_halt=1, mem_addr=dma_addr, mem_ce_n=mem_oe_n=~dma_cs, mem_we_n=1; dma_data=mem_din combinationally (zero latency).
REQ-016 DMA with dma_hold=0: next state RELEASE. RELEASE: strobes high, hlda=0, cpu_halt=1 for 1 cycle, then CPU.
REQ-017 Grant latency: from dma_hold sampled high in CPU (idle) to state DMA is 2 clk. This matches the VPU, which asserts dma_cs 2 cycles after hold.
REQ-018 dma_cs=1 in any state other than DMA: dma_data=8'hFF and dma_err set; dma_err clears only on reset.
REQ-019 cpu_di outside CPU/CPU_WAIT: the last value captured on the final cycle of the previous CPU read.
REQ-020 dma_hold dropping during SWITCH: the FSM still goes SWITCH->DMA->RELEASE (no abort path).

Reset
REQ-021 On rst: state=CPU, cpu_halt=0, hlda=0, dma_err=0, wait counter=0, cpu_di capture=0.
REQ-022 On rst: mem_ce_n, mem_oe_n and mem_we_n are forced high.
REQ-023 rst asserted mid-DMA or mid-wait: the bus is released immediately and asynchronously; no partial write is completed.

Configuration
REQ-024 Macro VRAM_ARB_WAIT_EN.
- Defined: CPU_WAIT and the wait counter are present and WAIT_STATES takes effect.
- Undefined: WAIT_STATES is ignored, CPU_WAIT is unreachable and not synthesized, every CPU access is 1 cycle, and cpu_halt is high only in SWITCH, DMA and RELEASE.

Structure
REQ-025 Package vram_arb_pkg holds the FSM state encoding, the WAIT_STATES maximum (7) and the idle strobe constant.
REQ-026 Single module; no sub-module. The wait counter is 3 bits, inline.

Verification
REQ-027 CPU write 0x5A to 0x1234, WAIT_STATES=0 -> mem_we_n low for 1 cycle, mem_addr=0x1234, mem_dout=0x5A, cpu_halt=0.
REQ-028 CPU read with WAIT_STATES=2, mem_din=0xC3 -> cpu_halt high 2 cycles, mem_oe_n low 3 cycles, cpu_di=0xC3.
REQ-029 dma_hold rises at cycle 0 while idle -> SWITCH at cycle 1, hlda=1 at cycle 2; dma_cs at cycle 2 with dma_addr=0x8000 -> dma_data=mem_din, dma_err=0.
REQ-030 dma_hold rises during a 3-cycle CPU access -> access completes first, then SWITCH; dma_cs issued before DMA -> dma_data=0xFF, dma_err=1.
REQ-031 rst pulsed while in DMA -> next edge state=CPU, all strobes high, hlda=0, cpu_halt=0.
REQ-032 Build without VRAM_ARB_WAIT_EN and WAIT_STATES=3 -> CPU reads complete in 1 cycle with cpu_halt=0.
